dmem_responder: RTL and testbench



---
 rtl/dmem_pkg.sv | 12 +
 rtl/dmem_array.sv | 44 ++++
 rtl/dmem_responder.sv | 142 ++++++++++++++
 tb/tb_dmem_responder.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  localparam logic [31:0] FAULT_RDATA = 32'h0;

endpackage

// File: rtl/dmem_array.sv
// Word array with per-byte write enables and a registered read port.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [3:0]    wr_be,
  input  logic [AW-1:0] idx,
  input  logic [31:0]   wdata,
  input  logic          rd_en,
  input  logic          rd_fault,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] rdata_d, rdata_q;

  // NOTE: the storage array has no reset; clearing it would force a flop-based
  // implementation instead of a RAM, and stored data must survive reset anyway.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    if (rd_en) rdata_d = rd_fault ? FAULT_RDATA : mem[idx];
  end

  always_ff @(posedge clk) begin
    if (reset) rdata_q <= FAULT_RDATA;
    else       rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one request, inserts WAIT_CYCLES wait states, then
// completes it. Define DMEM_SWB_EN to enable byte stores via mem_byte.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic        mem_byte,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_done,
  output logic        mem_busy,
  output logic        mem_err
);

  localparam int          AW        = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_e      state_d, state_q;
  logic [3:0]  cnt_d, cnt_q;
  logic [31:0] addr_d, addr_q, wdata_d, wdata_q;
  logic        byte_d, byte_q, rd_d, rd_q, wr_d, wr_q;
  logic        done_d, done_q, err_d, err_q, busy_d, busy_q;
  logic        enter_resp, byte_eff, fault;
  logic [3:0]  arr_be;
  logic [31:0] arr_wdata;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    byte_d     = byte_q;
    rd_d       = rd_q;
    wr_d       = wr_q;
    enter_resp = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (mem_read || mem_write) begin
          addr_d  = mem_addr;
          wdata_d = mem_wdata;
          byte_d  = mem_byte;
          rd_d    = mem_read;
          wr_d    = mem_write;
          if (WAIT_CYCLES == 0) begin
            state_d    = S_RESP;
            cnt_d      = 4'd0;
            enter_resp = 1'b1;
          end else begin
            state_d = S_WAIT;
            cnt_d   = WAIT_LOAD;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d    = S_RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // The access decode uses the _d view so a zero-wait request is checked on the accept edge.
`ifdef DMEM_SWB_EN
  assign byte_eff  = byte_d;
  assign arr_be    = byte_d ? (4'b0001 << addr_d[1:0]) : 4'hF;
  assign arr_wdata = byte_d ? {4{wdata_d[7:0]}} : wdata_d;
`else
  assign byte_eff  = 1'b0;
  assign arr_be    = 4'hF;
  assign arr_wdata = wdata_d;
  logic unused_byte;
  assign unused_byte = byte_d;
`endif

  assign fault = (rd_d && wr_d)
              || (addr_d[31:2] >= 30'(DEPTH_WORDS))
              || ((addr_d[1:0] != 2'b00) && !(wr_d && !rd_d && byte_eff));

  always_comb begin
    done_d = enter_resp;
    err_d  = enter_resp && fault;
    busy_d = (state_d != S_IDLE);
  end

  // NOTE: every flop here is assigned with <= so all of them sample the same pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  // Request holding registers carry no reset: they are only read while a request is live.
  always_ff @(posedge clk) begin
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
    byte_q  <= byte_d;
    rd_q    <= rd_d;
    wr_q    <= wr_d;
  end

  dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_array (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (enter_resp && wr_d && !rd_d && !fault && !reset),
    .wr_be    (arr_be),
    .idx      (addr_d[2 +: AW]),
    .wdata    (arr_wdata),
    .rd_en    (enter_resp && rd_d && !wr_d && !reset),
    .rd_fault (fault),
    .rdata    (mem_rdata)
  );

  assign mem_done = done_q;
  assign mem_err  = err_q;
  assign mem_busy = busy_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed scoreboard bench for dmem_responder (WAIT_CYCLES=2, DEPTH_WORDS=256).
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        reset, mem_read, mem_write, mem_byte;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_done, mem_busy, mem_err;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    string       tag;
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model_mem [256];
  logic [31:0] last_rdata = 32'h0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_byte  (mem_byte),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_done  (mem_done),
    .mem_busy  (mem_busy),
    .mem_err   (mem_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_byte  = 1'b0;
    mem_addr  = 32'h0;
    mem_wdata = 32'h0;
  endtask

  // Issue one request, then follow it to completion. poke raises mem_read during WAIT.
  task automatic do_req(input string tag, input logic rd, input logic wr, input logic bt,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic exp_err, input bit poke);
    exp_t e;
    int   cyc;
    int   extra;
    bit   seen;
    logic bt_eff;
`ifdef DMEM_SWB_EN
    bt_eff = bt;
`else
    bt_eff = 1'b0;
`endif
    if (rd && !wr) begin
      last_rdata = exp_err ? 32'h0 : model_mem[addr[9:2]];
    end else if (wr && !rd && !exp_err) begin
      if (bt_eff) model_mem[addr[9:2]][8*addr[1:0] +: 8] = wdata[7:0];
      else        model_mem[addr[9:2]] = wdata;
    end
    e = '{tag, exp_err, last_rdata};
    sb.push_back(e);

    @(negedge clk);
    mem_read = rd; mem_write = wr; mem_byte = bt; mem_addr = addr; mem_wdata = wdata;
    @(posedge clk);
    #1 idle_inputs();
    check({tag, " busy_after_accept"}, mem_busy, 1'b1);

    cyc = 0; seen = 0;
    while (!seen && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (poke && cyc == 1) begin mem_read = 1'b1; mem_addr = 32'h0000_0010; end
      if (poke && cyc == 2) idle_inputs();
      if (mem_done === 1'b1) seen = 1;
    end
    check({tag, " done_latency"}, cyc, 3);
    e = sb.pop_front();
    if (seen) begin
      check({e.tag, " err"}, mem_err, e.err);
      check({e.tag, " rdata"}, mem_rdata, e.rdata);
      check({e.tag, " busy_in_resp"}, mem_busy, 1'b1);
    end
    @(negedge clk);
    check({tag, " done_one_cycle"}, mem_done, 1'b0);
    check({tag, " err_one_cycle"}, mem_err, 1'b0);
    check({tag, " busy_released"}, mem_busy, 1'b0);
    if (poke) begin
      extra = 0;
      repeat (6) begin
        @(negedge clk);
        if (mem_done === 1'b1) extra++;
      end
      check({tag, " no_queued_done"}, extra, 0);
    end
  endtask

  initial begin
    int extra;
    logic exp_byte_err;
    reset = 1'b1;
    idle_inputs();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset done", mem_done, 1'b0);
    check("reset err", mem_err, 1'b0);
    check("reset busy", mem_busy, 1'b0);
    check("reset rdata", mem_rdata, 32'h0);

    do_req("wr_10", 0, 1, 0, 32'h10, 32'hCAFEF00D, 0, 0);
    do_req("rd_10", 1, 0, 0, 32'h10, 32'h0, 0, 0);
    do_req("rd_13_misaligned", 1, 0, 0, 32'h13, 32'h0, 1, 0);
    do_req("rd_10_after_fault", 1, 0, 0, 32'h10, 32'h0, 0, 0);
    do_req("rd_out_of_range", 1, 0, 0, 32'h400, 32'h0, 1, 0);
    do_req("rd_10_after_range", 1, 0, 0, 32'h10, 32'h0, 0, 0);
    do_req("rd_last_word", 1, 0, 0, 32'h3FC, 32'h0, 0, 0);
    do_req("wr_last_word", 0, 1, 0, 32'h3FC, 32'h600DF00D, 0, 0);
    do_req("rd_last_word2", 1, 0, 0, 32'h3FC, 32'h0, 0, 0);

`ifdef DMEM_SWB_EN
    exp_byte_err = 1'b0;
`else
    exp_byte_err = 1'b1;
`endif
    do_req("wr_20", 0, 1, 0, 32'h20, 32'h11223344, 0, 0);
    do_req("swb_22", 0, 1, 1, 32'h22, 32'h000000AB, exp_byte_err, 0);
    do_req("rd_20", 1, 0, 0, 32'h20, 32'h0, 0, 0);

    do_req("both_high", 1, 1, 0, 32'h10, 32'h12345678, 1, 0);
    do_req("wr_misaligned", 0, 1, 0, 32'h11, 32'h87654321, 1, 0);
    do_req("rd_10_unchanged", 1, 0, 0, 32'h10, 32'h0, 0, 0);

    do_req("wr_30_poked", 0, 1, 0, 32'h30, 32'h55AA0001, 0, 1);
    do_req("rd_30", 1, 0, 0, 32'h30, 32'h0, 0, 0);

    // Reset on the last WAIT cycle of a write: the write must be dropped.
    do_req("wr_08", 0, 1, 0, 32'h08, 32'h0BADBEEF, 0, 0);
    do_req("rd_08", 1, 0, 0, 32'h08, 32'h0, 0, 0);
    @(negedge clk);
    mem_write = 1'b1; mem_addr = 32'h08; mem_wdata = 32'hDEADDEAD;
    @(posedge clk);
    #1 idle_inputs();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    last_rdata = 32'h0;
    @(negedge clk);
    check("midwait_reset done", mem_done, 1'b0);
    check("midwait_reset err", mem_err, 1'b0);
    check("midwait_reset busy", mem_busy, 1'b0);
    check("midwait_reset rdata", mem_rdata, 32'h0);
    extra = 0;
    repeat (4) begin
      @(negedge clk);
      if (mem_done === 1'b1) extra++;
    end
    check("midwait_reset no_done", extra, 0);
    do_req("rd_08_after_reset", 1, 0, 0, 32'h08, 32'h0, 0, 0);

    // Reset and request in the same cycle: the request is not accepted.
    @(negedge clk);
    reset = 1'b1; mem_read = 1'b1; mem_addr = 32'h10;
    @(posedge clk);
    #1 begin reset = 1'b0; idle_inputs(); end
    last_rdata = 32'h0;
    @(negedge clk);
    check("reset_wins busy", mem_busy, 1'b0);
    check("reset_wins rdata", mem_rdata, 32'h0);
    extra = 0;
    repeat (5) begin
      @(negedge clk);
      if (mem_done === 1'b1) extra++;
    end
    check("reset_wins no_done", extra, 0);
    do_req("rd_20_final", 1, 0, 0, 32'h20, 32'h0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: bench did not finish, observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
